// File: rtl/block_data_memory_pkg.sv
// Shared types and default sizing for the block data memory.
// Optional byte-mask write support is enabled with DMEM_BYTE_MASK_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_BLOCK_BYTES  = 16;
    localparam int DEF_DEPTH_BLOCKS = 16;
    localparam int DEF_ADDR_W       = 28;
    localparam int DEF_LATENCY      = 5;

    // Counter only ever holds LATENCY-1, but must be at least one bit wide.
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

    localparam int DEF_IDX_W = $clog2(DEF_DEPTH_BLOCKS);
    localparam int DEF_CNT_W = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/block_data_memory_if.sv
// Request/response bundle between the data cache and the block data memory.
// BYTEMASK exists only when DMEM_BYTE_MASK_EN is defined.
interface block_data_memory_if
    import dmem_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int ADDR_W      = DEF_ADDR_W
);
    logic                     READ;
    logic                     WRITE;
    logic [ADDR_W-1:0]        ADDRESS;
    logic [8*BLOCK_BYTES-1:0] WRITEDATA;
`ifdef DMEM_BYTE_MASK_EN
    logic [BLOCK_BYTES-1:0]   BYTEMASK;
`endif
    logic [8*BLOCK_BYTES-1:0] READDATA;
    logic                     BUSYWAIT;
    logic                     ERROR;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
`ifdef DMEM_BYTE_MASK_EN
        output BYTEMASK,
`endif
        input  READDATA, BUSYWAIT, ERROR
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
`ifdef DMEM_BYTE_MASK_EN
        input  BYTEMASK,
`endif
        output READDATA, BUSYWAIT, ERROR
    );
endinterface

// File: rtl/block_data_memory_latency_ctr.sv
// Loadable down-counter with zero flag that times one memory access.
// Load wins over decrement; decrement saturates at zero.
module dmem_latency_ctr
    import dmem_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/block_data_memory.sv
// Block-oriented data memory with cycle-counted latency and BUSYWAIT handshake.
// Byte-masked writes are compiled in with DMEM_BYTE_MASK_EN.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int BLOCK_BYTES  = DEF_BLOCK_BYTES,
    parameter int DEPTH_BLOCKS = DEF_DEPTH_BLOCKS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LATENCY      = DEF_LATENCY
) (
    input logic                CLOCK,
    input logic                RESET,
    block_data_memory_if.slave bus
);
    localparam int DATA_W = 8 * BLOCK_BYTES;
    localparam int IDX_W  = $clog2(DEPTH_BLOCKS);
    localparam int CNT_W  = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic                   op_wr_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [BLOCK_BYTES-1:0] mask_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [DATA_W-1:0]      mem_q [DEPTH_BLOCKS];

    logic valid_req, illegal_req;
    logic busy, err, capture, access, dec, cnt_zero;
    logic unused_addr_bits;

    assign valid_req   = bus.READ ^ bus.WRITE;
    assign illegal_req = bus.READ & bus.WRITE;
    // Upper address bits alias onto the low index bits by design.
    assign unused_addr_bits = ^bus.ADDRESS[ADDR_W-1:IDX_W];

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        err     = 1'b0;
        capture = 1'b0;
        access  = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = valid_req;
                err  = illegal_req;
                if (valid_req) begin
                    capture = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                dec  = 1'b1;
                if (cnt_zero) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    dmem_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .load_i     (capture),
        .load_val_i (LOAD_VAL),
        .dec_i      (dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (capture) begin
                op_wr_q <= bus.WRITE;
                idx_q   <= bus.ADDRESS[IDX_W-1:0];
                wdata_q <= bus.WRITEDATA;
`ifdef DMEM_BYTE_MASK_EN
                mask_q  <= bus.BYTEMASK;
`else
                mask_q  <= '1;
`endif
            end
            if (access && !op_wr_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH_BLOCKS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (access && op_wr_q) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (mask_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Reset forces the handshake outputs low even while a request is held.
    assign bus.BUSYWAIT = busy & ~RESET;
    assign bus.ERROR    = err & ~RESET;
    assign bus.READDATA = rdata_q;
endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: driver queues expected completions,
// a negedge monitor checks latency and read data when BUSYWAIT falls.
module tb_block_data_memory;
    import dmem_pkg::*;

    localparam int BB  = 16;
    localparam int DW  = 8 * BB;
    localparam int AW  = 28;
    localparam int LAT = 5;

    localparam logic [DW-1:0] D2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DW-1:0] D3 = 128'hDEADBEEF_01234567_89ABCDEF_A5A5A5A5;
    localparam logic [DW-1:0] D4 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_data_memory_if #(.BLOCK_BYTES(BB), .ADDR_W(AW)) bus ();

    block_data_memory #(
        .BLOCK_BYTES  (BB),
        .DEPTH_BLOCKS (16),
        .ADDR_W       (AW),
        .LATENCY      (LAT)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic          is_rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    int            tests    = 0;
    int            fails    = 0;
    int            busy_cnt = 0;
    logic [DW-1:0] last_rd  = '0;
    logic [BB-1:0] mask_unused;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts BUSYWAIT-high samples, checks each completion on the fall.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else if (bus.BUSYWAIT) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_completion: got completion expected none");
            end else begin
                e = expq.pop_front();
                check("busy_cycles", DW'(busy_cnt), DW'(LAT + 1));
                if (e.is_rd) check("readdata", bus.READDATA, e.data);
            end
            busy_cnt = 0;
        end
    end

    task automatic access(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [BB-1:0] mask, input logic [DW-1:0] exp_rd, input int drop_after);
        exp_t e;
        int   n;
        @(posedge clk);
        #2;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
`ifdef DMEM_BYTE_MASK_EN
        bus.BYTEMASK  = mask;
`endif
        mask_unused   = mask;
        bus.READ      = rd;
        bus.WRITE     = !rd;
        e.is_rd = rd;
        e.data  = exp_rd;
        expq.push_back(e);
        if (rd) last_rd = exp_rd;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!bus.BUSYWAIT) break;
            if (n == drop_after) begin
                bus.READ  = 1'b0;
                bus.WRITE = 1'b0;
            end
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL busywait_timeout: got still busy after %0d cycles expected done", n);
                break;
            end
        end
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic reset_mid(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_busywait"}, DW'(bus.BUSYWAIT), '0);
        check({tag, "_error"}, DW'(bus.ERROR), '0);
        check({tag, "_readdata"}, bus.READDATA, '0);
        expq.delete();
        last_rd   = '0;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = '0;
        bus.WRITEDATA = '0;
`ifdef DMEM_BYTE_MASK_EN
        bus.BYTEMASK  = '0;
`endif
        #2;
        check("por_busywait", DW'(bus.BUSYWAIT), '0);
        check("por_error", DW'(bus.ERROR), '0);
        check("por_readdata", bus.READDATA, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Write then read block 2, back to back.
        access(1'b0, 28'h2, D2, '1, '0, 0);
        access(1'b1, 28'h2, '0, '1, D2, 0);

        // Reset in the middle of a read; memory must come back zeroed.
        @(posedge clk);
        #2;
        bus.ADDRESS = 28'h2;
        bus.READ    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_mid("rst_read");
        access(1'b1, 28'h3, '0, '1, '0, 0);
        access(1'b1, 28'h2, '0, '1, '0, 0);

        // Write block 1 with request dropped during BUSY; read through aliases.
        access(1'b0, 28'h1, D3, '1, '0, 3);
        access(1'b1, 28'h11, '0, '1, D3, 0);
        access(1'b1, 28'hABCDEF1, '0, '1, D3, 0);

        // Illegal request: ERROR high, no busy, no side effect.
        @(posedge clk);
        #2;
        bus.ADDRESS   = 28'h1;
        bus.WRITEDATA = D4;
        bus.READ      = 1'b1;
        bus.WRITE     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_error", DW'(bus.ERROR), DW'(1));
            check("illegal_busywait", DW'(bus.BUSYWAIT), '0);
            check("illegal_readdata", bus.READDATA, last_rd);
        end
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
        @(negedge clk);
        check("illegal_error_clear", DW'(bus.ERROR), '0);
        access(1'b1, 28'h1, '0, '1, D3, 0);

        // Reset while a write to block 4 sits at counter 2.
        @(posedge clk);
        #2;
        bus.ADDRESS   = 28'h4;
        bus.WRITEDATA = D4;
        bus.WRITE     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_mid("rst_write");
        access(1'b1, 28'h4, '0, '1, '0, 0);
        access(1'b0, 28'h14, D4, '1, '0, 0);
        access(1'b1, 28'h4, '0, '1, D4, 0);

`ifdef DMEM_BYTE_MASK_EN
        access(1'b0, 28'h0, {DW{1'b1}}, 16'hFFFF, '0, 0);
        access(1'b0, 28'h0, '0, 16'h000F, '0, 0);
        access(1'b1, 28'h0, '0, '1, {{96{1'b1}}, 32'h0}, 0);
        access(1'b0, 28'h0, '0, 16'h0000, '0, 0);
        access(1'b1, 28'h0, '0, '1, {{96{1'b1}}, 32'h0}, 0);
`else
        access(1'b0, 28'h0, D2, 16'h000F, '0, 0);
        access(1'b1, 28'h10, '0, '1, D2, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", DW'(expq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
